if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 121 ++++++++++++
 tb/tb_if_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch sequencer: issues one outstanding req/ack fetch at a time,
// buffers returned words in a small FIFO for IF/ID, and steers the PC register.
module if_fetch_unit #(
   parameter int unsigned DEPTH   = 2,
   parameter logic [31:0] PC_STEP = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic [31:0] pc_next,
   output logic        pc_freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   input  logic        id_freeze,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]    r_state;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_instr [DEPTH];
   logic [31:0]   r_pc    [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic w_valid;
   logic w_push;
   logic w_pop;

   assign w_valid = (r_count != '0);
   // A branch in the ack cycle kills the returning word.
   assign w_push  = rst && (r_state == S_WAIT) && mem_ack && !branch_taken;
   assign w_pop   = w_valid && !id_freeze && !branch_taken;

   // Branch redirect outranks the sequential advance from an accepted ack.
   always_comb begin
      pc_next   = pc_in + PC_STEP;
      pc_freeze = 1'b1;
      if (rst) begin
         if (branch_taken) begin
            pc_next   = branch_addr;
            pc_freeze = 1'b0;
         end else if (w_push) begin
            pc_freeze = 1'b0;
         end
      end
   end

   assign mem_req  = (r_state != S_IDLE);
   assign mem_addr = r_mem_addr;
   assign if_valid = w_valid;
   assign if_instr = w_valid ? r_instr[r_rptr] : '0;
   assign if_pc    = w_valid ? r_pc[r_rptr]    : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_mem_addr <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Issue gated on registered occupancy so a push can never overflow.
               if ((r_count < CW'(DEPTH)) && !branch_taken) begin
                  r_state    <= S_WAIT;
                  r_mem_addr <= pc_in;
               end
            end
            S_WAIT: begin
               if (mem_ack)
                  r_state <= S_IDLE;
               else if (branch_taken)
                  r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (mem_ack)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         if (branch_taken) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
         end else begin
            if (w_push)
               r_wptr <= r_wptr + PW'(1);
            if (w_pop)
               r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)
               r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
               r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr[r_wptr] <= mem_rdata;
         r_pc[r_wptr]    <= r_mem_addr + PC_STEP;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural PC register closing the loop.
module tb_if_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc_in;
   logic [31:0] pc_next;
   logic        pc_freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        id_freeze;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   logic [31:0] pc_reg;
   int          total;
   int          bad;

   if_fetch_unit #(.DEPTH(2), .PC_STEP(32'd4)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_in        (pc_in),
      .pc_next      (pc_next),
      .pc_freeze    (pc_freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .id_freeze    (id_freeze),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .if_valid     (if_valid),
      .if_instr     (if_instr),
      .if_pc        (if_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register the fetch unit drives.
   always @(posedge clk) begin
      if (!rst)
         pc_reg <= 32'd0;
      else if (!pc_freeze)
         pc_reg <= pc_next;
   end
   assign pc_in = pc_reg;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic frz);
      rst          = 1'b0;
      mem_ack      = 1'b0;
      mem_rdata    = 32'd0;
      branch_taken = 1'b0;
      branch_addr  = 32'd0;
      id_freeze    = frz;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Two zero-wait fetches from 0x0 and 0x4 with id_freeze held.
   task automatic fill_two();
      tick();
      chk("fill_req0", 32'(mem_req), 32'd1);
      chk("fill_addr0", mem_addr, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
      #1;
      chk("fill_pcn0", pc_next, 32'h4);
      tick();
      mem_ack = 1'b0;
      tick();
      chk("fill_addr1", mem_addr, 32'h4);
      mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
      tick();
      mem_ack = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // Reset state
      do_reset(1'b0);
      rst = 1'b0;
      #1;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_freeze", 32'(pc_freeze), 32'd1);

      // 1: basic fetch with 2-cycle memory latency
      rst = 1'b1;
      tick();
      chk("t1_req", 32'(mem_req), 32'd1);
      chk("t1_addr", mem_addr, 32'h0);
      chk("t1_frz_wait", 32'(pc_freeze), 32'd1);
      tick();
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hE3A0_0001;
      #1;
      chk("t1_frz_ack", 32'(pc_freeze), 32'd0);
      chk("t1_pcnext", pc_next, 32'h4);
      tick();
      mem_ack = 1'b0;
      chk("t1_valid", 32'(if_valid), 32'd1);
      chk("t1_instr", if_instr, 32'hE3A0_0001);
      chk("t1_ifpc", if_pc, 32'h4);
      chk("t1_pcreg", pc_in, 32'h4);

      // 2: fill FIFO under id_freeze, then drain
      do_reset(1'b1);
      fill_two();
      chk("t2_req_full", 32'(mem_req), 32'd0);
      chk("t2_head_instr", if_instr, 32'h1111_1111);
      chk("t2_head_pc", if_pc, 32'h4);
      tick();
      chk("t2_noreq_a", 32'(mem_req), 32'd0);
      tick();
      chk("t2_noreq_b", 32'(mem_req), 32'd0);
      id_freeze = 1'b0;
      tick();
      chk("t2_pop1_pc", if_pc, 32'h8);
      chk("t2_pop1_instr", if_instr, 32'h2222_2222);
      chk("t2_pop1_req", 32'(mem_req), 32'd0);
      tick();
      chk("t2_empty", 32'(if_valid), 32'd0);
      chk("t2_resume_req", 32'(mem_req), 32'd1);
      chk("t2_resume_addr", mem_addr, 32'h8);

      // 3: branch while WAIT, late ack discarded in DRAIN
      do_reset(1'b0);
      tick();
      branch_taken = 1'b1; branch_addr = 32'h100;
      #1;
      chk("t3_pcnext", pc_next, 32'h100);
      chk("t3_frz", 32'(pc_freeze), 32'd0);
      tick();
      branch_taken = 1'b0;
      #1;
      chk("t3_frz_after", 32'(pc_freeze), 32'd1);
      chk("t3_drain_req", 32'(mem_req), 32'd1);
      chk("t3_drain_addr", mem_addr, 32'h0);
      tick();
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t3_ack_frz", 32'(pc_freeze), 32'd1);
      tick();
      mem_ack = 1'b0;
      chk("t3_novalid", 32'(if_valid), 32'd0);
      chk("t3_noinstr", if_instr, 32'd0);
      chk("t3_idle", 32'(mem_req), 32'd0);
      tick();
      chk("t3_new_req", 32'(mem_req), 32'd1);
      chk("t3_new_addr", mem_addr, 32'h100);

      // 4: branch and ack in the same cycle
      do_reset(1'b0);
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      branch_taken = 1'b1; branch_addr = 32'h200;
      #1;
      chk("t4_pcnext", pc_next, 32'h200);
      chk("t4_frz", 32'(pc_freeze), 32'd0);
      tick();
      mem_ack = 1'b0; branch_taken = 1'b0;
      chk("t4_nopush", 32'(if_valid), 32'd0);
      chk("t4_idle", 32'(mem_req), 32'd0);
      tick();
      chk("t4_req", 32'(mem_req), 32'd1);
      chk("t4_addr", mem_addr, 32'h200);

      // 5: full FIFO flushed by branch
      do_reset(1'b1);
      fill_two();
      chk("t5_full_valid", 32'(if_valid), 32'd1);
      branch_taken = 1'b1; branch_addr = 32'h300;
      #1;
      chk("t5_pcnext", pc_next, 32'h300);
      tick();
      branch_taken = 1'b0;
      chk("t5_flush_valid", 32'(if_valid), 32'd0);
      chk("t5_flush_instr", if_instr, 32'd0);
      tick();
      chk("t5_req", 32'(mem_req), 32'd1);
      chk("t5_addr", mem_addr, 32'h300);

      // 6: reset in WAIT, late ack ignored
      do_reset(1'b0);
      tick();
      chk("t6_wait_req", 32'(mem_req), 32'd1);
      rst = 1'b0;
      #1;
      chk("t6_rst_frz", 32'(pc_freeze), 32'd1);
      tick();
      chk("t6_req_drop", 32'(mem_req), 32'd0);
      chk("t6_valid", 32'(if_valid), 32'd0);
      rst = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
      #1;
      chk("t6_late_frz", 32'(pc_freeze), 32'd1);
      tick();
      mem_ack = 1'b0;
      chk("t6_late_nopush", 32'(if_valid), 32'd0);
      chk("t6_late_pc", pc_in, 32'h0);

      // 7: PC wrap at the top of the address space
      do_reset(1'b0);
      branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
      tick();
      branch_taken = 1'b0;
      chk("t7_idle", 32'(mem_req), 32'd0);
      tick();
      chk("t7_addr", mem_addr, 32'hFFFF_FFFC);
      mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
      #1;
      chk("t7_pcnext", pc_next, 32'h0);
      tick();
      mem_ack = 1'b0;
      chk("t7_ifpc", if_pc, 32'h0);
      chk("t7_instr", if_instr, 32'h7777_7777);
      chk("t7_pcreg", pc_in, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
